frame_stream_source: RTL and testbench
======================================

Name: frame_stream_source

Overview:
- Transmit side of the valid/ready pixel stream that feeds first_word_fall_through_fifo and the crop datapath.
- Holds one IN_ROWS x IN_COLS frame in an internal synchronous-read RAM, loaded through a simple write port.
- On start, streams the frame in raster order with strict valid/ready semantics.
- Tags beats with start-of-frame, end-of-line and end-of-frame flags, and pulses done once the last beat is accepted.

Parameters:
- DATA_WIDTH, 8, pixel width in bits (FP_TOTAL).
- ROWS, 9, frame rows.
- COLS, 9, frame columns.
- DEPTH, ROWS*COLS, frame size in beats.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  reset, asynchronous assert, active-low (0 = in reset); synchronous deassert is external.
- wr_en  in  1  frame-RAM write strobe.
- wr_addr  in  ADDR_WIDTH  write address, raster index row*COLS+col.
- wr_data  in  DATA_WIDTH  write data.
- start  in  1  begin streaming the stored frame; sampled only in IDLE.
- busy  out  1  high from the accepted start until the final beat handshake.
- done  out  1  one-cycle pulse after the final beat handshake.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  pixel.
- out_sof  out  1  beat is index 0.
- out_eol  out  1  beat is the last column of a row.
- out_eof  out  1  beat is index DEPTH-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy, done, out_valid, out_sof, out_eol and out_eof go to 0; out_data goes to 0.
  - FSM goes to IDLE; read/beat counters and skid occupancy are cleared.
  - RAM contents are not reset.
- Writes:
  - Accepted only when busy=0; wr_en while busy=1 is ignored.
  - A write to address A and a start in the same cycle: the write lands and the stream sees the new data.
- FSM has two states, IDLE and STREAM.
  - IDLE: start=1 at edge E moves to STREAM; busy=1 after E; rd_idx=0.
  - STREAM: start is ignored.
  - On the out_valid&&out_ready handshake of the beat with out_eof=1, move to IDLE: busy=0 and done=1 for exactly one cycle after that edge.
- Read pipeline:
  - RAM read latency is 1 cycle; read data enters stream_skid_buffer (2 entries).
  - A read is issued when rd_idx<DEPTH and (reads in flight + skid occupancy - pop this cycle) < 2. This guarantees no overflow.
- Latency and throughput:
  - out_valid rises 2 cycles after the edge that samples start.
  - With out_ready held at 1, throughput is 1 beat/cycle: DEPTH consecutive beats, no bubbles.
- Tags (computed from the read index and carried alongside the data through the skid):
  - out_sof = (idx==0).
  - out_eol = (col==COLS-1), using a col counter that wraps to 0 at COLS-1 and a row counter incremented on wrap.
  - out_eof = (idx==DEPTH-1).
- Handshake rules:
  - Once out_valid=1, out_data and the three tags stay stable until the handshake.
  - out_valid never depends combinationally on out_ready.
  - No beat is dropped or duplicated under any out_ready pattern.
- Boundaries:
  - DEPTH=1: that beat carries sof, eol and eof together.
  - out_ready=1 with out_valid=0 has no effect.
  - A new start is accepted in the cycle done is high, since the FSM is already in IDLE.
- Reset mid-stream: immediate abort per the reset rules; the next start replays from index 0.
- Counter widths: idx uses ADDR_WIDTH+1 bits so rd_idx==DEPTH is representable. The row counter uses $clog2(ROWS) bits; the col counter uses $clog2(COLS) bits.

Decomposition:
- Shared package crop_pkg:
  - Constants FP_TOTAL, FP_FRAC, IN_ROWS, IN_COLS.
  - typedef pixel_t = logic [FP_TOTAL-1:0].
  - typedef struct beat_t {pixel_t data; logic sof, eol, eof;}.
  - typedef enum src_state_t {IDLE, STREAM}.
- Sub-module stream_skid_buffer: 2-entry register FIFO over beat_t with push/pop/count, reused by other streaming blocks.
- RAM inferred inline.

Test Plan:
- Load data=i for i=0..80, start, out_ready=1 constant:
  - 81 beats 0..80 on consecutive cycles; first out_valid 2 cycles after start.
  - sof on beat 0 only; eol on beats 8,17,...,80; eof on beat 80 only.
  - done pulses once, then busy=0.
- Same frame with random out_ready (50%), 20 seeds:
  - Beats arrive in order 0..80 with no loss or duplication.
  - out_data and tags held stable whenever out_valid=1 && out_ready=0.
- out_ready=0 for 10 cycles after the first beat appears: out_valid stays 1 with beat 0 held; on release, beats 0..80 complete in order.
- Pulse start and write addr 5 := 0xFF mid-stream: both are ignored; the stream completes with beat 5 = 5 and exactly one done.
- Assert reset (reset=0) after beat 40's handshake:
  - All outputs read 0 immediately.
  - After release and start, the stream restarts at beat 0 with RAM data intact (0..80).
- Write 0xAA to addr 0 in the same cycle as start: the first beat is 0xAA with sof=1.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared types for the crop streaming path: pixel format, beat bundle
// carried through skid buffers, and the frame source FSM states.
package crop_pkg;

    localparam int FP_TOTAL = 8;
    localparam int FP_FRAC  = 4;
    localparam int IN_ROWS  = 9;
    localparam int IN_COLS  = 9;

    typedef logic [FP_TOTAL-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   sof;
        logic   eol;
        logic   eof;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } src_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry register FIFO of beat_t; head is always slot 0 so the output
// only changes on a pop (or the first push into an empty buffer).
// Ports: clk, rst_n, push_i/data_i in, pop_i in, data_o head, count_o 0..2.
module stream_skid_buffer
    import crop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  beat_t      data_i,
    output beat_t      data_o,
    output logic [1:0] count_o
);

    beat_t      slot_q [2];
    beat_t      slot_d [2];
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       pop_v;
    logic       push_v;

    assign pop_v  = pop_i && (cnt_q != 2'd0);
    assign push_v = push_i && ((cnt_q != 2'd2) || pop_v);

    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (pop_v) begin
            slot_d[0] = slot_q[1];
            cnt_d     = cnt_d - 2'd1;
        end
        if (push_v) begin
            // after the optional shift, the free slot is the occupancy
            slot_d[cnt_d[0]] = data_i;
            cnt_d            = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            cnt_q     <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o  = slot_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/frame_stream_source.sv
// Frame RAM plus raster-order valid/ready streamer with sof/eol/eof tags.
// Ports: clk, reset (async, active-low), wr_en/wr_addr/wr_data RAM load,
// start, busy, done pulse, out_valid/out_ready/out_data/out_sof/eol/eof.
module frame_stream_source
    import crop_pkg::*;
#(
    parameter int DATA_WIDTH = FP_TOTAL,
    parameter int ROWS       = IN_ROWS,
    parameter int COLS       = IN_COLS,
    parameter int DEPTH      = ROWS * COLS,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
);

    localparam int IW = ADDR_WIDTH + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    src_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    pixel_t        mem [DEPTH];
    pixel_t        rdata_q;
    logic          inflight_q;
    logic          sof_q, eol_q, eof_q;
    logic          done_q;

    logic          rd_en;
    logic          pop;
    logic          last_col;
    logic          last_row;
    logic [1:0]    cnt;
    logic [2:0]    occ;
    beat_t         head;
    beat_t         rbeat;

    assign last_col = (col_q == CW'(COLS - 1));
    assign last_row = (row_q == RW'(ROWS - 1));
    assign pop      = out_ready && (cnt != 2'd0);
    // slots that will be committed after this edge, excluding a new read
    assign occ      = {1'b0, cnt} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            STREAM: begin
                rd_en = (idx_q < IW'(DEPTH)) && (occ < 3'd2);
                if (rd_en) begin
                    idx_d = idx_q + 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (pop && head.eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rdata_q    <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            inflight_q <= rd_en;
            done_q     <= pop && head.eof;
            if (rd_en) begin
                rdata_q <= mem[idx_q[ADDR_WIDTH-1:0]];
                sof_q   <= (idx_q == '0);
                eol_q   <= last_col;
                eof_q   <= last_col && last_row;
            end
        end
    end

    // frame storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < IW'(DEPTH))) begin
            mem[wr_addr] <= FP_TOTAL'(wr_data);
        end
    end

    assign rbeat = '{data: rdata_q, sof: sof_q, eol: eol_q, eof: eof_q};

    stream_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  (rbeat),
        .data_o  (head),
        .count_o (cnt)
    );

    assign busy      = (state_q == STREAM);
    assign done      = done_q;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = DATA_WIDTH'(head.data);
    assign out_sof   = out_valid && head.sof;
    assign out_eol   = out_valid && head.eol;
    assign out_eof   = out_valid && head.eof;

endmodule

// File: tb/tb_frame_stream_source.sv
// Randomised self-checking bench for frame_stream_source against a
// frame-level reference model of pixel order and tag rules.
module tb_frame_stream_source;

    localparam int DW    = 8;
    localparam int ROWS  = 9;
    localparam int COLS  = 9;
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid;
    logic [DW-1:0] out_data;
    logic          out_sof, out_eol, out_eof;

    frame_stream_source dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [10:0]   got_q [$];
    int            first_valid;
    int            last_acc;
    int            done_cnt;
    int            stab_err;
    int            timed_out;

    function automatic logic [10:0] exp_beat(input int i);
        logic s, l, f;
        s = (i == 0);
        l = ((i % COLS) == COLS - 1);
        f = (i == DEPTH - 1);
        return {model_mem[i], s, l, f};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drives out_ready per mode and records accepted beats (no checking).
    // mode 0: ready=1, 1: random, 2: 10-cycle stall, 3: ready=1 + pokes.
    task automatic capture(input int mode, input int budget);
        int          c;
        int          stall;
        int          post;
        bit          pend;
        bit          seen_done;
        logic [10:0] held;
        logic [10:0] cur;
        c = 0; stall = 0; post = 0; pend = 0; seen_done = 0; held = '0;
        got_q.delete();
        first_valid = -1; last_acc = -1; done_cnt = 0;
        stab_err = 0; timed_out = 0;
        while (1) begin
            cur = {out_data, out_sof, out_eol, out_eof};
            if (pend && (!out_valid || cur !== held)) stab_err++;
            if (out_valid && first_valid < 0) first_valid = c;
            if (done) begin
                done_cnt++;
                seen_done = 1;
            end
            if (mode == 3 && c == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 7'd5; wr_data = 8'hFF;
            end else if (mode == 3 && c == 3) begin
                start = 1'b0; wr_en = 1'b0;
            end
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && stall < 10) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                last_acc = c;
            end
            pend = out_valid && !out_ready;
            held = cur;
            if (seen_done) post++;
            if (post > 3) break;
            if (c >= budget) begin
                timed_out = 1;
                break;
            end
            step();
            c++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic load_frame();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_addr = AW'(i);
            wr_data = DW'(i);
            model_mem[i] = DW'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] o;
        #3;
        o = {busy, done, out_valid, out_data, out_sof, out_eol, out_eof};
        tests++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_async outs=%h want 0", o);
        end
        step();
        step();
        o = {busy, done, out_valid, out_data, out_sof, out_eol, out_eof};
        tests++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_held outs=%h want 0", o);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_full_ready();
        do_start();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL full_busy got=%b want 1", busy);
        end
        capture(0, 300);
        tests++;
        if (timed_out != 0) begin
            fails++;
            $display("FAIL full_timeout got=%0d beats want %0d", got_q.size(), DEPTH);
        end
        tests++;
        if (first_valid != 2) begin
            fails++;
            $display("FAIL full_latency got=%0d want 2", first_valid);
        end
        tests++;
        if (got_q.size() != DEPTH) begin
            fails++;
            $display("FAIL full_count got=%0d want %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            tests++;
            if (got_q[i] !== exp_beat(i)) begin
                fails++;
                $display("FAIL full_beat%0d got=%h want %h", i, got_q[i], exp_beat(i));
            end
        end
        tests++;
        if (last_acc - first_valid != DEPTH - 1) begin
            fails++;
            $display("FAIL full_bubbles span=%0d want %0d", last_acc - first_valid, DEPTH - 1);
        end
        tests++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_done pulses=%0d busy=%b want 1,0", done_cnt, busy);
        end
    endtask

    task automatic test_random_ready();
        for (int s = 0; s < 20; s++) begin
            do_start();
            capture(1, 2000);
            tests++;
            if (got_q.size() != DEPTH || timed_out != 0) begin
                fails++;
                $display("FAIL rand%0d_count got=%0d want %0d", s, got_q.size(), DEPTH);
            end
            for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
                tests++;
                if (got_q[i] !== exp_beat(i)) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d got=%h want %h", s, i, got_q[i], exp_beat(i));
                end
            end
            tests++;
            if (stab_err != 0 || done_cnt != 1) begin
                fails++;
                $display("FAIL rand%0d_stable unstable=%0d done=%0d want 0,1", s, stab_err, done_cnt);
            end
        end
    endtask

    task automatic test_stall();
        do_start();
        capture(2, 500);
        tests++;
        if (got_q.size() != DEPTH || timed_out != 0) begin
            fails++;
            $display("FAIL stall_count got=%0d want %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            tests++;
            if (got_q[i] !== exp_beat(i)) begin
                fails++;
                $display("FAIL stall_beat%0d got=%h want %h", i, got_q[i], exp_beat(i));
            end
        end
        tests++;
        if (stab_err != 0 || last_acc - first_valid != DEPTH + 9) begin
            fails++;
            $display("FAIL stall_hold unstable=%0d span=%0d want 0,%0d", stab_err, last_acc - first_valid, DEPTH + 9);
        end
    endtask

    task automatic test_ignore_midstream();
        do_start();
        capture(3, 300);
        tests++;
        if (got_q.size() != DEPTH || done_cnt != 1) begin
            fails++;
            $display("FAIL ignore_count got=%0d done=%0d want %0d,1", got_q.size(), done_cnt, DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            tests++;
            if (got_q[i] !== exp_beat(i)) begin
                fails++;
                $display("FAIL ignore_beat%0d got=%h want %h", i, got_q[i], exp_beat(i));
            end
        end
    endtask

    task automatic test_reset_midstream();
        int          acc;
        int          c;
        logic [14:0] o;
        acc = 0;
        c = 0;
        do_start();
        out_ready = 1'b1;
        while (acc < 41 && c < 300) begin
            if (out_valid) acc++;
            step();
            c++;
        end
        tests++;
        if (acc != 41) begin
            fails++;
            $display("FAIL rstmid_reach got=%0d want 41", acc);
        end
        reset = 1'b0;
        #1;
        o = {busy, done, out_valid, out_data, out_sof, out_eol, out_eof};
        tests++;
        if (o !== '0) begin
            fails++;
            $display("FAIL rstmid_outs got=%h want 0", o);
        end
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        do_start();
        capture(0, 300);
        tests++;
        if (got_q.size() != DEPTH || first_valid != 2) begin
            fails++;
            $display("FAIL rstmid_replay got=%0d lat=%0d want %0d,2", got_q.size(), first_valid, DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            tests++;
            if (got_q[i] !== exp_beat(i)) begin
                fails++;
                $display("FAIL rstmid_beat%0d got=%h want %h", i, got_q[i], exp_beat(i));
            end
        end
    endtask

    task automatic test_write_with_start();
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 8'hAA;
        model_mem[0] = 8'hAA;
        do_start();
        wr_en = 1'b0;
        capture(0, 300);
        tests++;
        if (got_q.size() == 0 || got_q[0] !== {8'hAA, 3'b100}) begin
            fails++;
            $display("FAIL wrstart_first got=%h want %h", got_q.size() ? got_q[0] : 11'h0, {8'hAA, 3'b100});
        end
        tests++;
        if (got_q.size() != DEPTH) begin
            fails++;
            $display("FAIL wrstart_count got=%0d want %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            tests++;
            if (got_q[i] !== exp_beat(i)) begin
                fails++;
                $display("FAIL wrstart_beat%0d got=%h want %h", i, got_q[i], exp_beat(i));
            end
        end
    endtask

    initial begin
        test_reset();
        load_frame();
        test_full_ready();
        test_random_ready();
        test_stall();
        test_ignore_midstream();
        test_reset_midstream();
        test_write_with_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
